// File: rtl/keypad_scan_pkg.sv
// Shared constants, state encoding and helpers for the 16-key pad scanner.
package keypad_scan_pkg;

  localparam int IDX_W    = 4;
  localparam int NUM_KEYS = 16;
  localparam int CNT_W    = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_SCAN    = 2'd0;
  localparam state_t ST_CONFIRM = 2'd1;
  localparam state_t ST_EMIT    = 2'd2;
  localparam state_t ST_RELEASE = 2'd3;

  // Next index in scan order; the 4-bit width makes 15 wrap to 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer, resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops to resolve metastability on the async input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner_16.sv
// Scans a 16-key pad one index at a time, debounces press and release on the
// shared sense line, and offers one key code per press on a valid/ready port.
module keypad_scanner_16 #(
  parameter int SETTLE_CYCLES = 4,
  parameter int DEBOUNCE      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sense_in,
  output logic [3:0] scan_idx,
  output logic       scan_active,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready
);

  import keypad_scan_pkg::*;

  localparam int DW_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [DW_W-1:0]  LAST_DWELL = DW_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_TARGET = CNT_W'(DEBOUNCE);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_cand;
  logic [DW_W-1:0]    r_dwell;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_sense_s;
  logic               w_run;
  logic               w_tick;
  logic [CNT_W-1:0]   w_cnt_inc;

  sync_2ff u_sense_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (sense_in),
    .o_q   (w_sense_s)
  );

  // The dwell timer only pauses when scanning is idle-disabled; a press in
  // progress keeps its timing regardless of enable.
  assign w_run     = !((r_state == ST_SCAN) && !enable);
  assign w_tick    = w_run && (r_dwell == LAST_DWELL);
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Dwell counter: 0..SETTLE_CYCLES-1, tick on the last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell <= '0;
    end else if (w_run) begin
      r_dwell <= w_tick ? '0 : r_dwell + DW_W'(1);
    end
  end

  // Scan / confirm / emit / release sequencing, all decisions on dwell ticks
  // except the consumer handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SCAN;
      r_idx   <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_SCAN: begin
          if (w_tick) begin
            if (w_sense_s) begin
              r_cand  <= r_idx;
              r_cnt   <= CNT_W'(1);
              r_state <= (DEBOUNCE == 1) ? ST_EMIT : ST_CONFIRM;
            end else begin
              r_idx <= next_idx(r_idx);
            end
          end
        end
        ST_CONFIRM: begin
          if (w_tick) begin
            if (w_sense_s) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == DEB_TARGET) begin
                r_state <= ST_EMIT;
              end
            end else begin
              // Sense dropped before the press was accepted: a glitch.
              r_idx   <= next_idx(r_cand);
              r_state <= ST_SCAN;
            end
          end
        end
        ST_EMIT: begin
          if (key_ready) begin
            r_cnt   <= '0;
            r_state <= ST_RELEASE;
          end
        end
        default: begin
          if (w_tick) begin
            if (!w_sense_s) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == DEB_TARGET) begin
                r_idx   <= next_idx(r_cand);
                r_state <= ST_SCAN;
              end
            end else begin
              r_cnt <= '0;
            end
          end
        end
      endcase
    end
  end

  assign scan_idx    = r_idx;
  assign scan_active = (r_state == ST_SCAN);
  assign key_valid   = (r_state == ST_EMIT);
  assign key_code    = r_cand;

endmodule

// File: tb/tb_keypad_scanner_16.sv
// Bench for keypad_scanner_16: keypad model on the sense line, expected key
// codes queued by the stimulus and checked by an independent monitor.
module tb_keypad_scanner_16;

  localparam int S = 4;
  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       sense_in;
  logic       key_ready;
  logic [3:0] scan_idx;
  logic [3:0] key_code;
  logic       scan_active;
  logic       key_valid;

  logic [15:0] mask = '0;
  logic        glitch = 1'b0;
  bit          ready_rand = 1'b0;
  logic        ready_fix = 1'b1;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_q[$];
  bit          holding = 1'b0;
  logic [3:0]  cur_code = '0;

  always #5 clk = ~clk;

  // Pad model: the key at the driven index closes the sense line.
  assign sense_in = mask[scan_idx] | glitch;

  keypad_scanner_16 #(.SETTLE_CYCLES(S), .DEBOUNCE(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .sense_in    (sense_in),
    .scan_idx    (scan_idx),
    .scan_active (scan_active),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Consumer ready: fixed level or a coin toss per cycle.
  always @(posedge clk) begin
    #1;
    key_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  // Monitor: every new key offered must match the head of the queue and stay
  // stable until the handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      holding = 1'b0;
    end else if (key_valid) begin
      if (!holding) begin
        if (exp_q.size() == 0) chk("unexpected_key", int'(key_code), -1);
        else chk("key_code", int'(key_code), exp_q.pop_front());
        holding  = 1'b1;
        cur_code = key_code;
      end else begin
        chk("code_stable", int'(key_code), int'(cur_code));
      end
      if (key_ready) holding = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    chk("reset_idx", int'(scan_idx), 0);
    chk("reset_active", int'(scan_active), 1);
    chk("reset_valid", int'(key_valid), 0);
    chk("reset_code", int'(key_code), 0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_xfer(input string nm, input int budget);
    for (int i = 0; i < budget && (exp_q.size() != 0 || holding); i++) tick();
    chk(nm, int'(exp_q.size() == 0 && !holding), 1);
  endtask

  task automatic wait_scan(input string nm, input int budget);
    for (int i = 0; i < budget && !scan_active; i++) tick();
    chk(nm, int'(scan_active), 1);
  endtask

  task automatic wait_idx(input string nm, input int v, input int budget);
    for (int i = 0; i < budget && int'(scan_idx) != v; i++) tick();
    chk(nm, int'(scan_idx), v);
  endtask

  task automatic wait_valid(input string nm, input int budget);
    for (int i = 0; i < budget && !key_valid; i++) tick();
    chk(nm, int'(key_valid), 1);
  endtask

  initial begin
    int lat;
    int start;
    int expk;
    logic [15:0] m;

    key_ready = 1'b1;

    // Idle scanning: the index advances once every S cycles.
    do_reset();
    for (int n = 0; n < 17 * S; n++) begin
      tick();
      chk("scan_step", int'(scan_idx), ((n + 1) / S) % 16);
    end

    // Key 5 held through reset: first key_valid after S*(k+D) post-reset edges.
    mask = 16'(1) << 5;
    do_reset();
    exp_q.push_back(5);
    lat = -1;
    for (int e = 0; e < 80 && lat < 0; e++) begin
      tick();
      if (key_valid) lat = e + 1;
    end
    chk("latency_k5", lat, S * (5 + D));
    tick();
    chk("valid_one_cycle", int'(key_valid), 0);
    repeat (100) tick();
    chk("long_press_release_wait", int'(scan_active), 0);
    mask = '0;
    wait_scan("k5_back_to_scan", 60);
    chk("k5_resume_idx", int'(scan_idx), 6);

    // One-dwell glitch at index 9.
    do_reset();
    wait_idx("reach_9", 9, 80);
    glitch = 1'b1;
    repeat (4) tick();
    chk("glitch_confirm", int'(scan_active), 0);
    glitch = 1'b0;
    wait_scan("glitch_back_to_scan", 30);
    chk("glitch_resume_idx", int'(scan_idx), 10);
    repeat (10) tick();
    chk("glitch_no_valid", int'(key_valid), 0);

    // Key 15 with the consumer stalled.
    do_reset();
    ready_fix = 1'b0;
    mask = 16'(1) << 15;
    exp_q.push_back(15);
    wait_valid("k15_valid", 150);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("k15_hold_valid", int'(key_valid), 1);
      chk("k15_hold_code", int'(key_code), 15);
    end
    ready_fix = 1'b1;
    wait_xfer("k15_xfer", 10);
    mask = '0;
    wait_scan("k15_back_to_scan", 60);
    chk("k15_wrap_idx", int'(scan_idx), 0);

    // Keys 3 and 12 together: 3 first, then 12 once 3 is released.
    do_reset();
    mask = (16'(1) << 3) | (16'(1) << 12);
    exp_q.push_back(3);
    wait_xfer("k3_xfer", 100);
    mask = 16'(1) << 12;
    exp_q.push_back(12);
    wait_xfer("k12_xfer", 150);
    mask = '0;
    wait_scan("k12_back_to_scan", 60);
    chk("k12_resume_idx", int'(scan_idx), 13);

    // Reset asserted mid-emit drops key_valid without waiting for a clock.
    do_reset();
    ready_fix = 1'b0;
    mask = 16'(1) << 7;
    exp_q.push_back(7);
    wait_valid("k7_valid", 120);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", int'(key_valid), 0);
    chk("async_idx", int'(scan_idx), 0);
    chk("async_active", int'(scan_active), 1);
    tick();
    mask = '0;
    exp_q.delete();
    ready_fix = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("post_reset_idx", int'(scan_idx), 0);
    chk("post_reset_active", int'(scan_active), 1);

    // enable low freezes scanning at index 4.
    do_reset();
    wait_idx("reach_4", 4, 40);
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("freeze_idx", int'(scan_idx), 4);
      chk("freeze_active", int'(scan_active), 1);
    end
    enable = 1'b1;
    wait_idx("resume_5", 5, S + 1);

    // Random presses of 1..3 keys with a random consumer; the winner is the
    // first pressed key reached in circular order from the resume index.
    do_reset();
    ready_rand = 1'b1;
    start = 0;
    for (int r = 0; r < 12; r++) begin
      m = '0;
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) m[$urandom_range(0, 15)] = 1'b1;
      expk = -1;
      for (int off = 0; off < 16 && expk < 0; off++) begin
        if (m[(start + off) % 16]) expk = (start + off) % 16;
      end
      exp_q.push_back(expk);
      mask = m;
      wait_xfer("rand_xfer", 600);
      mask = '0;
      wait_scan("rand_back_to_scan", 80);
      start = (expk + 1) % 16;
      chk("rand_resume_idx", int'(scan_idx), start);
    end
    ready_rand = 1'b0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
